// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide sequencer.
//   muldiv_op_t    : operation code as presented on the `op` port.
//   muldiv_state_t : sequencer control states.
//   MULDIV_WIDTH   : default operand width.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } muldiv_state_t;

    function automatic logic op_is_signed(input muldiv_op_t o);
        return (o == MULT) || (o == DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t o);
        return (o == DIV) || (o == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Multicycle multiply/divide sequencer owning the HI/LO registers.
// Runs a radix-2 shift-add multiplier or a restoring divider for WIDTH
// iterations on operand magnitudes, then fixes up signs.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   start, op, a, b   : request and operands, sampled only in IDLE
//   cancel            : synchronous abort in PREP/ITER/FIX
//   busy              : high in every state except IDLE
//   done              : one-cycle completion pulse
//   div_zero          : with done, divide by zero (HI/LO untouched)
//   hi_lo_write       : with done, HI/LO were updated
//   hi, lo            : product upper/lower half, or remainder/quotient
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hi_lo_write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = 2 * WIDTH + 1;

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [AW-1:0]      acc_shl;
    logic [WIDTH+1:0]   alu_x, alu_y, alu_out;
    logic [2*WIDTH-1:0] product, product_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign is_div    = op_is_div(op_q);
    assign is_signed = op_is_signed(op_q);
    assign a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Shared adder/subtractor. Multiply adds the multiplicand (a) to the
    // upper half; divide subtracts the divisor (b) from the left-shifted
    // partial remainder, with the extra top bit acting as the borrow.
    assign acc_shl = {acc_q[AW-2:0], 1'b0};
    assign alu_x   = is_div ? {1'b0, acc_shl[AW-1:WIDTH]} : {2'b00, acc_q[AW-2:WIDTH]};
    assign alu_y   = {2'b00, is_div ? b_q : a_q};
    assign alu_out = is_div ? (alu_x - alu_y) : (alu_x + alu_y);

    assign product     = acc_q[2*WIDTH-1:0];
    assign product_fix = neg_res_q ? -product : product;
    assign quot_fix    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // NOTE: every *_d gets its hold value first so no path through the case leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                // cancel is deliberately ignored here
                if (start) begin
                    op_d      = muldiv_op_t'(op);
                    a_d       = a;
                    b_d       = b;
                    dz_d      = 1'b0;
                    neg_res_d = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = PREP;
                end
            end
            PREP: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    a_d       = a_mag;
                    b_d       = b_mag;
                    neg_res_d = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem_d = is_signed && a_q[WIDTH-1];
                    if (is_div && (b_q == '0)) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        // low half holds the multiplier or the dividend
                        acc_d   = {{(WIDTH+1){1'b0}}, is_div ? a_mag : b_mag};
                        count_d = CW'(WIDTH - 1);
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    if (is_div) begin
                        // restore on borrow, otherwise keep difference and set quotient bit
                        if (alu_out[WIDTH+1]) acc_d = acc_shl;
                        else                  acc_d = {alu_out[WIDTH:0], acc_shl[WIDTH-1:1], 1'b1};
                    end else if (acc_q[0]) begin
                        acc_d = {1'b0, alu_out[WIDTH:0], acc_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[AW-1:1]};
                    end
                    count_d = count_q - CW'(1);
                    if (count_q == '0) state_d = FIX;
                end
            end
            FIX: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    hi_d    = is_div ? rem_fix  : product_fix[2*WIDTH-1:WIDTH];
                    lo_d    = is_div ? quot_fix : product_fix[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= MULT;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign div_zero    = done && dz_q;
    assign hi_lo_write = done && !dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = MULDIV_WIDTH;

    logic         clock = 1'b0;
    logic         reset, start, cancel;
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, div_zero, hi_lo_write;

    int checks = 0;
    int errors = 0;

    // reference model state: architectural HI/LO and expected zero flag
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;

    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic         saw;
    int           lat;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi_lo_write (hi_lo_write),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Plain arithmetic reference: truncating division, remainder sign of dividend.
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx, sy;
        logic [63:0] p;
        exp_dz = 1'b0;
        case (muldiv_op_t'(o))
            MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {exp_hi, exp_lo} = p;
            end
            MULTU: begin
                p = 64'(x) * 64'(y);
                {exp_hi, exp_lo} = p;
            end
            DIV: begin
                if (y == '0) exp_dz = 1'b1;
                else begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    exp_lo = W'(sx / sy);
                    exp_hi = W'(sx % sy);
                end
            end
            default: begin
                if (y == '0) exp_dz = 1'b1;
                else begin
                    exp_lo = x / y;
                    exp_hi = x % y;
                end
            end
        endcase
    endtask

    // Issue one operation, wait for done, check latency, flags, result and return to idle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic with_cancel);
        int n;
        model(o, x, y);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y; cancel = with_cancel;
        @(posedge clock); #1;
        start = 1'b0; cancel = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'(1));
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), exp_dz ? 64'(1) : 64'(W + 2));
        check({tag, " flags"}, 64'({done, div_zero, hi_lo_write}), 64'({1'b1, exp_dz, !exp_dz}));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clock); #1;
        check({tag, " idle"}, 64'({busy, done}), 64'(0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        #12;
        check("reset flags", 64'({busy, done, div_zero, hi_lo_write}), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        @(negedge clock); reset = 1'b0;

        // directed cases
        run_op("mult 7x6",   MULT,  32'd7,          32'd6, 1'b0);
        run_op("mult -3x5",  MULT,  -32'sd3,        32'd5, 1'b0);
        run_op("multu ffx2", MULTU, 32'hFFFF_FFFF,  32'd2, 1'b0);
        run_op("div -7/2",   DIV,   -32'sd7,        32'd2, 1'b0);
        run_op("divu 100/7", DIVU,  32'd100,        32'd7, 1'b0);
        run_op("div min/-1", DIV,   32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op("divu preset", DIVU, 32'h5555,       32'h100, 1'b0);
        check("preset hi 55", 64'(hi), 64'(32'h55));
        run_op("divu 7/0",   DIVU,  32'd7,          32'd0, 1'b0);
        run_op("div 5/0",    DIV,   32'd5,          32'd0, 1'b0);
        run_op("start+cancel idle", MULTU, 32'd11,  32'd13, 1'b1);

        // random operations against the model
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = '0;
                1: r_b = W'($urandom_range(1, 15));
                2: r_a = 32'h8000_0000;
                3: r_b = '1;
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), r_op, r_a, r_b, 1'b0);
        end

        // cancel during ITER: no done, HI/LO keep the last result
        @(negedge clock);
        start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (11) @(posedge clock);
        @(negedge clock); cancel = 1'b1;
        @(posedge clock); #1;
        cancel = 1'b0;
        check("cancel idle", 64'({busy, done}), 64'(0));
        saw = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done || busy) saw = 1'b1;
        end
        check("cancel no done", 64'(saw), 64'(0));
        check("cancel hi", 64'(hi), 64'(exp_hi));
        check("cancel lo", 64'(lo), 64'(exp_lo));

        // start while busy is ignored
        model(MULTU, 32'h1234, 32'h10);
        @(negedge clock);
        start = 1'b1; op = MULTU; a = 32'h1234; b = 32'h10;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        repeat (4) begin @(posedge clock); #1; lat++; end
        @(negedge clock);
        start = 1'b1; op = DIV; a = 32'd1; b = 32'd1;
        @(posedge clock); #1;
        start = 1'b0;
        lat++;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        check("busy start latency", 64'(lat), 64'(W + 2));
        check("busy start hi", 64'(hi), 64'(exp_hi));
        check("busy start lo", 64'(lo), 64'(exp_lo));
        saw = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (busy) saw = 1'b1;
        end
        check("busy start not queued", 64'(saw), 64'(0));

        // asynchronous reset mid-operation
        @(negedge clock);
        start = 1'b1; op = MULT; a = 32'd123456; b = 32'd789;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        #1;
        check("midreset flags", 64'({busy, done, div_zero, hi_lo_write}), 64'(0));
        check("midreset hi", 64'(hi), 64'(0));
        check("midreset lo", 64'(lo), 64'(0));
        exp_hi = '0; exp_lo = '0;
        @(negedge clock); reset = 1'b0;
        run_op("mult 3x3 after reset", MULT, 32'd3, 32'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multicycle multiply/divide sequencer for the MIPS-style multicycle datapath. It accepts a MULT/MULTU/DIV/DIVU request from the main control FSM and runs a radix-2 shift-add multiplier or restoring divider for WIDTH iterations. It owns the HI/LO registers and signals completion with a one-cycle pulse, so the control FSM can stall or poll `busy`.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation, decoded per the package encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  multiplicand or dividend; sampled with `start`.
- `b`  in  WIDTH  multiplier or divisor; sampled with `start`.
- `cancel`  in  1  synchronous abort of the operation in progress.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  pulses together with `done` when DIV/DIVU has `b`==0.
- `hi_lo_write`  out  1  pulses with `done` when HI/LO were updated.
- `hi`  out  WIDTH  HI register: product upper half or remainder.
- `lo`  out  WIDTH  LO register: product lower half or quotient.

## Operation
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `div_zero`, `hi_lo_write` are 0.
  - `hi` and `lo` are 0.
  - Internal accumulator, counter and latched operands are 0.
- IDLE:
  - `start`=1 latches `op`, `a`, `b`, then goes to PREP.
  - `start` together with `cancel` in IDLE: `cancel` is ignored and the start is accepted.
- PREP:
  - Signed ops take magnitudes of `a` and `b` and record the result sign and the remainder sign (the dividend sign).
  - DIV/DIVU with `b`==0 goes to DONE with the zero flag set.
  - Otherwise goes to ITER with counter = WIDTH−1.
- ITER: one shift-add or one restoring-subtract step per cycle; the counter decrements. Leaves for FIX after the step taken at counter 0, giving exactly WIDTH iterations.
- FIX: signed ops conditionally two's-complement negate the product (2·WIDTH bits), the quotient and the remainder.
- DONE:
  - `done`=1 for one cycle, then IDLE.
  - Normal completion: HI/LO are written on entry to DONE and `hi_lo_write`=1.
  - Divide by zero: HI/LO are unchanged, `hi_lo_write`=0, `div_zero`=1.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - MULT/MULTU give the full 2·WIDTH-bit product.
  - DIV of −2^(WIDTH−1) by −1 gives LO=0x80000000 and HI=0 (WIDTH=32). No exception is raised.
- `cancel` in PREP, ITER or FIX: next state is IDLE. No `done`, HI/LO unchanged.
- `start` while `busy` is ignored; the inputs are not re-latched.

## Timing
- Edge numbering: the edge that samples `start` is edge 0.
- Normal latency: `done` is high in the cycle after edge WIDTH+2, i.e. 35 cycles for WIDTH=32.
- Divide-by-zero latency: `done` is high in the cycle after edge 1.
- `busy` rises after edge 0 and falls after the edge that leaves DONE.
- `busy` is low in the cycle after `done`.
- Back-to-back operation: a new `start` is accepted in the cycle after `done`.
- `hi` and `lo` change only at the edge entering DONE and are stable from the `done` cycle onward.
- Asynchronous reset mid-operation immediately forces every reset value above, including `hi`=`lo`=0.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` enum: MULT, MULTU, DIV, DIVU.
  - `muldiv_state_t` enum: IDLE, PREP, ITER, FIX, DONE.
  - `MULDIV_WIDTH` default constant.
- Single module, no sub-modules. The product and division datapath share one 2·WIDTH+1-bit accumulator register with one adder/subtractor.
- Next-state and datapath-control logic is combinational with full default assignments; state and datapath registers are in a single `always_ff`.

## Test plan
- MULT a=7, b=6 → `done` at cycle 35, `hi`=0, `lo`=42, `hi_lo_write`=1.
- MULT a=−3, b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULTU a=0xFFFFFFFF, b=2 → `hi`=1, `lo`=0xFFFFFFFE.
- DIV a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=100, b=7 → `lo`=14, `hi`=2.
- DIVU a=7, b=0 with prior `hi`=`lo`=0x55 → `done` and `div_zero` at cycle 2, `hi_lo_write`=0, HI/LO stay 0x55.
- `cancel` at ITER cycle 10 → IDLE next cycle, no `done`. `start` at cycle 5 of a busy operation → ignored; the first operation's result is unchanged.
- `reset` pulsed at cycle 20 of a MULT → all outputs 0 immediately. A new MULT 3×3 after reset → `lo`=9 at 35 cycles.
